// File: rtl/mem_burst_ctrl.sv
// Line-granular memory controller: one cache-line read or write per request, issued as a tagged
// bus request followed by BEATS data beats. Optional response watchdog: MEMCTRL_TIMEOUT_EN.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module mem_burst_ctrl #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_WIDTH     = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [63:0]               req_addr,
    input  logic                      req_we,
    input  logic [LINE_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [LINE_WIDTH-1:0]     resp_data,
    output logic                      resp_we,
    output logic                      resp_err,
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic [2:0]                dbg_state
);
    localparam int BEATS = LINE_WIDTH / BUS_DATA_WIDTH;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [BUS_TAG_WIDTH-1:0] RD_TAG =
        BUS_TAG_WIDTH'({`SYSBUS_READ, `SYSBUS_MEMORY, 8'h00});
    localparam logic [BUS_TAG_WIDTH-1:0] WR_TAG =
        BUS_TAG_WIDTH'({`SYSBUS_WRITE, `SYSBUS_MEMORY, 8'h00});

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [63-OFF_W:0]      addr_q, addr_d;
    logic                   we_q, we_d;
    logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0]  line_q, line_d;
    logic [CNT_W-2:0]       beat_idx;
    logic [63:0]            line_addr;
    logic                   unused_bits;

    assign beat_idx    = cnt_q[CNT_W-2:0];
    assign line_addr   = {addr_q, {OFF_W{1'b0}}};
    assign unused_bits = ^{bus_resptag, req_addr[OFF_W-1:0]};
    assign dbg_state   = state_q;
    assign resp_data   = line_q;
    assign resp_we     = (state_q == RESP) & we_q;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    assign resp_err = (state_q == RESP) & err_q;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        line_d      = line_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
`ifdef MEMCTRL_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr[63:OFF_W];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = REQ;
                    // A read starts from an empty line so missing beats come back as zero.
                    if (!req_we) line_d = '0;
`ifdef MEMCTRL_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                end
            end
            REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'(line_addr);
                bus_reqtag = we_q ? WR_TAG : RD_TAG;
                if (bus_reqack) state_d = we_q ? WDATA : RDATA;
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_reqtag = WR_TAG;
                bus_req    = wdata_q[beat_idx*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) state_d = RESP;
            end
            RDATA: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc) begin
                    line_d[beat_idx*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef MEMCTRL_TIMEOUT_EN
        // wd_q counts cycles since the last bus event (or state entry) while waiting on the bus.
        if (state_q == REQ || state_q == RDATA) wd_d = wd_q + 1'b1;
        if (state_d != state_q || (state_q == REQ && bus_reqack) ||
            (state_q == RDATA && bus_respcyc)) wd_d = WD_W'(1);
        if (((state_q == REQ && !bus_reqack) || (state_q == RDATA && !bus_respcyc)) &&
            wd_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = RESP;
            err_d   = 1'b1;
            wd_d    = WD_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
`ifdef MEMCTRL_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
`ifdef MEMCTRL_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: table of line transactions driven against a bus/consumer model,
// with a response scoreboard, plus hand sequences for back-pressure, mid-burst reset and watchdog.

module tb_mem_burst_ctrl;
    localparam int BDW   = 64;
    localparam int TW    = 13;
    localparam int LW    = 512;
    localparam int BEATS = LW / BDW;
    localparam int TMO   = 16;
    localparam logic [TW-1:0] RD_TAG = 13'h1100;
    localparam logic [TW-1:0] WR_TAG = 13'h0100;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [63:0]    req_addr = '0;
    logic [LW-1:0]  req_wdata = '0;
    logic           resp_valid, resp_ready = 1'b0, resp_we, resp_err;
    logic [LW-1:0]  resp_data;
    logic           bus_reqcyc, bus_respack, bus_respcyc = 1'b0, bus_reqack = 1'b0;
    logic [BDW-1:0] bus_req, bus_resp = '0;
    logic [TW-1:0]  bus_reqtag, bus_resptag = '0;
    logic [2:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [LW-1:0] exp_q[$];
    logic          exp_we_q[$];
    logic          exp_err_q[$];
    logic [LW-1:0] last_rd = '0;

    typedef struct {
        logic [63:0]   addr;
        logic          we;
        int            ack_dly;
        int            stall_at;
        int            stall_len;
        int            mode;
        int            rdy_dly;
        logic [63:0]   exp_breq;
        logic [TW-1:0] exp_tag;
    } vec_t;
    vec_t vecs[6];

    mem_burst_ctrl #(
        .BUS_DATA_WIDTH(BDW), .BUS_TAG_WIDTH(TW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_we(resp_we), .resp_err(resp_err),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_reqack(bus_reqack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag), .dbg_state(dbg_state)
    );

    // clock / global time bound
    always #5 clk = ~clk;
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got no end, required end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] make_line(input int mode);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < BEATS; i++) begin
            case (mode)
                0:       l[i*BDW +: BDW] = 64'(i + 1) * 64'h11;
                1:       l[i*BDW +: BDW] = 64'(i + 1);
                default: l[i*BDW +: BDW] = {$urandom, $urandom};
            endcase
        end
        return l;
    endfunction

    // driver tasks: each starts just after a negedge and ends just after a later negedge
    task automatic send_req(input logic [63:0] a, input logic we, input logic [LW-1:0] d);
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = d;
        #1;
        chk("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0; req_wdata = '0;
    endtask

    task automatic req_phase(input int ack_dly, input logic [63:0] breq, input logic [TW-1:0] tag);
        for (int k = 0; k <= ack_dly; k++) begin
            bus_reqack  = (k == ack_dly);
            bus_respcyc = (k != ack_dly);
            bus_resp    = 64'hbad0_bad0_bad0_bad0;
            #1;
            chk("req_cyc", bus_reqcyc, 1'b1);
            chk("req_addr", bus_req, breq);
            chk("req_tag", bus_reqtag, tag);
            chk("req_respack_idle", bus_respack, 1'b0);
            chk("req_ready_busy", req_ready, 1'b0);
            @(negedge clk);
        end
        bus_reqack = 1'b0; bus_respcyc = 1'b0;
    endtask

    task automatic read_beats(input logic [LW-1:0] line, input int stall_at, input int stall_len,
                              input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus_respcyc = 1'b0;
                    #1;
                    chk("stall_respack", bus_respack, 1'b0);
                    chk("stall_resp_valid", resp_valid, 1'b0);
                    @(negedge clk);
                end
            end
            bus_respcyc = 1'b1;
            bus_resp    = line[b*BDW +: BDW];
            #1;
            chk($sformatf("beat%0d_respack", b), bus_respack, 1'b1);
            chk($sformatf("beat%0d_resp_valid", b), resp_valid, 1'b0);
            @(negedge clk);
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic write_beats(input logic [LW-1:0] line);
        for (int b = 0; b < BEATS; b++) begin
            #1;
            chk($sformatf("wbeat%0d_cyc", b), bus_reqcyc, 1'b1);
            chk($sformatf("wbeat%0d_data", b), bus_req, line[b*BDW +: BDW]);
            chk($sformatf("wbeat%0d_tag", b), bus_reqtag, WR_TAG);
            chk($sformatf("wbeat%0d_resp_valid", b), resp_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    // scoreboard side: pop the expected response when the DUT presents one
    task automatic resp_phase(input int rdy_dly);
        logic [LW-1:0] ed;
        logic          ew, ee;
        int            w;
        w = 0;
        #1;
        chk("resp_latency", resp_valid, 1'b1);
        while (!resp_valid && w < 20) begin
            @(negedge clk); #1; w++;
        end
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no resp_valid in 20 cycles, expected resp_valid=1");
            return;
        end
        ed = exp_q.pop_front(); ew = exp_we_q.pop_front(); ee = exp_err_q.pop_front();
        for (int h = 0; h < rdy_dly; h++) begin
            resp_ready = 1'b0;
            req_valid = 1'b1; req_addr = 64'hdead_0000; req_we = 1'b0;
            #1;
            chk("hold_valid", resp_valid, 1'b1);
            chk("hold_data", resp_data, ed);
            chk("hold_we", resp_we, ew);
            chk("hold_err", resp_err, ee);
            chk("hold_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        #1;
        chk("resp_data", resp_data, ed);
        chk("resp_we", resp_we, ew);
        chk("resp_err", resp_err, ee);
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        chk("resp_release", resp_valid, 1'b0);
        chk("req_ready_after_resp", req_ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [LW-1:0] line;
        line = make_line(v.mode);
        exp_q.push_back(v.we ? last_rd : line);
        exp_we_q.push_back(v.we);
        exp_err_q.push_back(1'b0);
        if (!v.we) last_rd = line;
        send_req(v.addr, v.we, line);
        req_phase(v.ack_dly, v.exp_breq, v.exp_tag);
        if (v.we) write_beats(line);
        else      read_beats(line, v.stall_at, v.stall_len, BEATS);
        resp_phase(v.rdy_dly);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_we"}, resp_we, 1'b0);
        chk({tag, "_resp_err"}, resp_err, 1'b0);
        chk({tag, "_bus_reqcyc"}, bus_reqcyc, 1'b0);
        chk({tag, "_bus_respack"}, bus_respack, 1'b0);
        chk({tag, "_bus_req"}, bus_req, '0);
        chk({tag, "_bus_reqtag"}, bus_reqtag, '0);
        chk({tag, "_resp_data"}, resp_data, '0);
        chk({tag, "_state"}, dbg_state, 3'd0);
    endtask

    initial begin
        logic [LW-1:0] line;
        //             addr                    we    ack st  sl mode rdy exp_breq                tag
        vecs[0] = '{64'h1000,               1'b0, 2, -1, 0, 0,   0, 64'h1000,               RD_TAG};
        vecs[1] = '{64'h1038,               1'b0, 0,  4, 3, 2,   0, 64'h1000,               RD_TAG};
        vecs[2] = '{64'h2000,               1'b1, 1, -1, 0, 1,   5, 64'h2000,               WR_TAG};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFC7, 1'b0, 3,  0, 1, 2,   0, 64'hFFFF_FFFF_FFFF_FFC0, RD_TAG};
        vecs[4] = '{64'h12345,              1'b1, 0, -1, 0, 2,   0, 64'h12340,              WR_TAG};
        vecs[5] = '{64'h7f,                 1'b0, 1,  7, 2, 2,   2, 64'h40,                 RD_TAG};

        // reset block
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("post_rst");
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // reset in the middle of a read burst, at beat 4
        line = make_line(2);
        send_req(64'h3000, 1'b0, '0);
        req_phase(1, 64'h3000, RD_TAG);
        read_beats(line, -1, 0, 4);
        bus_respcyc = 1'b1; bus_resp = line[4*BDW +: BDW];
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        bus_respcyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        #1;
        chk("abort_req_ready", req_ready, 1'b1);
        run_vec(vecs[0]);
        run_vec(vecs[4]);

`ifdef MEMCTRL_TIMEOUT_EN
        // beats stop after beat 2; watchdog fires 16 cycles after the last beat
        line = make_line(2);
        @(negedge clk);
        send_req(64'h4000, 1'b0, '0);
        req_phase(0, 64'h4000, RD_TAG);
        read_beats(line, -1, 0, 3);
        line[LW-1:3*BDW] = '0;
        exp_q.push_back(line); exp_we_q.push_back(1'b0); exp_err_q.push_back(1'b1);
        last_rd = line;
        for (int j = 1; j < TMO; j++) begin
            #1;
            chk($sformatf("wd_wait%0d", j), resp_valid, 1'b0);
            @(negedge clk);
        end
        resp_phase(0);
`endif

        chk("scoreboard_drain", 32'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
